// File: rtl/polyphase_fir_pkg.sv
// Shared constants, symbol mapping and width helpers for the polyphase FIR transmit shaper.
package polyphase_fir_pkg;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_PAM4 = 1'b1
    } mode_e;

    localparam int SYM_W = 3;

    localparam logic signed [SYM_W-1:0] BPSK_POS  = 3'sd1;
    localparam logic signed [SYM_W-1:0] BPSK_NEG  = -3'sd1;
    localparam logic signed [SYM_W-1:0] PAM4_NEG3 = -3'sd3;
    localparam logic signed [SYM_W-1:0] PAM4_NEG1 = -3'sd1;
    localparam logic signed [SYM_W-1:0] PAM4_POS1 = 3'sd1;
    localparam logic signed [SYM_W-1:0] PAM4_POS3 = 3'sd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Worst-case sum of N products of a 3-bit symbol and a coefficient, kept exact.
    function automatic int acc_width(input int nb_coef, input int n_taps);
        return nb_coef + SYM_W + clog2(n_taps);
    endfunction

    function automatic int round_shift(input int nbf_coef, input int nbf_out);
        return nbf_coef - nbf_out;
    endfunction

    function automatic int round_bias(input int shift);
        return (shift > 0) ? (1 << (shift - 1)) : 0;
    endfunction

    // PAM4 levels follow Gray order so adjacent levels differ in one bit.
    function automatic logic signed [SYM_W-1:0] map_symbol(input logic [1:0] data,
                                                            input logic mode);
        logic signed [SYM_W-1:0] level;
        if (mode == MODE_PAM4) begin
            case (data)
                2'b00:   level = PAM4_NEG3;
                2'b01:   level = PAM4_NEG1;
                2'b11:   level = PAM4_POS1;
                default: level = PAM4_POS3;
            endcase
        end else begin
            level = data[0] ? BPSK_POS : BPSK_NEG;
        end
        return level;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Runtime-loadable coefficient register file that presents the taps of one polyphase branch.
module fir_coef_bank
    import polyphase_fir_pkg::*;
#(
    parameter  int OS        = 4,
    parameter  int N_TAPS_PH = 6,
    parameter  int NB_COEF   = 8,
    localparam int NC        = OS * N_TAPS_PH,
    localparam int AW        = clog2(NC),
    localparam int PW        = clog2(OS)
) (
    input  logic                           clock,
    input  logic                           i_reset,
    input  logic                           i_we,
    input  logic [AW-1:0]                  i_addr,
    input  logic [NB_COEF-1:0]             i_data,
    input  logic [PW-1:0]                  i_phase,
    output logic [N_TAPS_PH*NB_COEF-1:0]   o_coefs
);

    logic [NB_COEF-1:0] coef [NC];
    logic [AW-1:0]      rd_idx;

    // Writes beyond the populated range are dropped rather than aliased.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            for (int i = 0; i < NC; i++) begin
                coef[i] <= '0;
            end
        end else if (i_we && (int'(i_addr) < NC)) begin
            coef[i_addr] <= i_data;
        end
    end

    always_comb begin
        o_coefs = '0;
        rd_idx  = '0;
        for (int k = 0; k < N_TAPS_PH; k++) begin
            rd_idx = AW'(k * OS) + AW'(i_phase);
            o_coefs[k*NB_COEF +: NB_COEF] = coef[rd_idx];
        end
    end

endmodule

// File: rtl/polyphase_fir_tx.sv
// Polyphase FIR pulse shaper / upsampler: one BPSK or PAM4 symbol in, OS shaped samples out.
module polyphase_fir_tx
    import polyphase_fir_pkg::*;
#(
    parameter  int OS        = 4,
    parameter  int N_TAPS_PH = 6,
    parameter  int NB_COEF   = 8,
    parameter  int NBF_COEF  = 7,
    parameter  int NB_OUT    = 8,
    parameter  int NBF_OUT   = 6,
    localparam int NC        = OS * N_TAPS_PH,
    localparam int AW        = clog2(NC),
    localparam int PW        = clog2(OS)
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_mode,
    input  logic [1:0]          i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_coef_we,
    input  logic [AW-1:0]       i_coef_addr,
    input  logic [NB_COEF-1:0]  i_coef_data,
    output logic [NB_OUT-1:0]   o_data,
    output logic                o_valid,
    output logic [PW-1:0]       o_phase
);

    localparam int ACC_W = acc_width(NB_COEF, N_TAPS_PH);
    localparam int SHIFT = round_shift(NBF_COEF, NBF_OUT);
    localparam int EXT_W = ACC_W + 1;

    localparam logic signed [EXT_W-1:0] ROUND_BIAS = EXT_W'(round_bias(SHIFT));
    localparam logic signed [EXT_W-1:0] SAT_HI     = EXT_W'((1 << (NB_OUT - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SAT_LO     = EXT_W'(-(1 << (NB_OUT - 1)));

    logic [PW-1:0]                 phase;
    logic [PW-1:0]                 phase_d;
    logic                          en_d;
    logic signed [SYM_W-1:0]       sym [N_TAPS_PH];
    logic [N_TAPS_PH*NB_COEF-1:0]  phase_coefs;
    logic signed [NB_COEF-1:0]     tap_coef [N_TAPS_PH];
    logic signed [ACC_W-1:0]       acc;
    logic signed [EXT_W-1:0]       rounded;
    logic signed [NB_OUT-1:0]      sample;

    assign o_ready = i_enable && (phase == '0);

    // Stage 1: phase count, symbol intake (zero-stuffed on underrun) and pipeline tags.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            phase   <= '0;
            phase_d <= '0;
            en_d    <= 1'b0;
            for (int k = 0; k < N_TAPS_PH; k++) begin
                sym[k] <= '0;
            end
        end else begin
            en_d <= i_enable;
            if (i_enable) begin
                phase   <= (phase == PW'(OS - 1)) ? '0 : phase + PW'(1);
                phase_d <= phase;
                if (phase == '0) begin
                    for (int k = N_TAPS_PH - 1; k > 0; k--) begin
                        sym[k] <= sym[k-1];
                    end
                    sym[0] <= i_valid ? map_symbol(i_data, i_mode) : '0;
                end
            end
        end
    end

    fir_coef_bank #(
        .OS        (OS),
        .N_TAPS_PH (N_TAPS_PH),
        .NB_COEF   (NB_COEF)
    ) u_coef_bank (
        .clock   (clock),
        .i_reset (i_reset),
        .i_we    (i_coef_we),
        .i_addr  (i_coef_addr),
        .i_data  (i_coef_data),
        .i_phase (phase_d),
        .o_coefs (phase_coefs)
    );

    always_comb begin
        for (int k = 0; k < N_TAPS_PH; k++) begin
            tap_coef[k] = phase_coefs[k*NB_COEF +: NB_COEF];
        end
    end

    // Exact dot product, then round-half-up and clamp to the output range.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS_PH; k++) begin
            acc = acc + ACC_W'(sym[k]) * ACC_W'(tap_coef[k]);
        end
        rounded = (EXT_W'(acc) + ROUND_BIAS) >>> SHIFT;
        if (rounded > SAT_HI) begin
            sample = NB_OUT'(SAT_HI);
        end else if (rounded < SAT_LO) begin
            sample = NB_OUT'(SAT_LO);
        end else begin
            sample = NB_OUT'(rounded);
        end
    end

    // Stage 2 is clocked every cycle; a disabled slot only drops o_valid and holds the sample.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_phase <= '0;
        end else begin
            o_valid <= en_d;
            if (en_d) begin
                o_data  <= sample;
                o_phase <= phase_d;
            end
        end
    end

endmodule

// File: tb/tb_polyphase_fir_tx.sv
// Self-checking bench for polyphase_fir_tx: symbol-level reference model plus directed literal checks.
module tb_polyphase_fir_tx;

    localparam int OS        = 4;
    localparam int N_TAPS_PH = 6;
    localparam int NB_COEF   = 8;
    localparam int NBF_COEF  = 7;
    localparam int NB_OUT    = 8;
    localparam int NBF_OUT   = 6;
    localparam int NC        = OS * N_TAPS_PH;
    localparam int AW        = 5;
    localparam int PW        = 2;
    localparam int SHIFT     = NBF_COEF - NBF_OUT;
    localparam int OUT_MAX   = (1 << (NB_OUT - 1)) - 1;
    localparam int OUT_MIN   = -(1 << (NB_OUT - 1));

    logic                clock = 1'b0;
    logic                i_reset = 1'b1;
    logic                i_enable = 1'b0;
    logic                i_mode = 1'b0;
    logic [1:0]          i_data = 2'b00;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic                i_coef_we = 1'b0;
    logic [AW-1:0]       i_coef_addr = '0;
    logic [NB_COEF-1:0]  i_coef_data = '0;
    logic [NB_OUT-1:0]   o_data;
    logic                o_valid;
    logic [PW-1:0]       o_phase;

    always #5 clock = ~clock;

    polyphase_fir_tx #(
        .OS        (OS),
        .N_TAPS_PH (N_TAPS_PH),
        .NB_COEF   (NB_COEF),
        .NBF_COEF  (NBF_COEF),
        .NB_OUT    (NB_OUT),
        .NBF_OUT   (NBF_OUT)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_mode      (i_mode),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_coef_we   (i_coef_we),
        .i_coef_addr (i_coef_addr),
        .i_coef_data (i_coef_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_phase     (o_phase)
    );

    int checks = 0;
    int failures = 0;
    int dut_log[$];
    int exp_log[$];

    // Reference state: symbol history (newest first), coefficient table, pending output slot.
    int m_hist[N_TAPS_PH];
    int m_coef[NC];
    int m_phase = 0;
    bit pend_valid = 1'b0;
    int pend_phase = 0;
    bit exp_valid = 1'b0;
    int exp_data = 0;
    int exp_phase = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int map_ref(input logic [1:0] d, input logic m);
        if (!m) return d[0] ? 1 : -1;
        case (d)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    function automatic int shape(input int p);
        int s;
        int r;
        s = 0;
        for (int k = 0; k < N_TAPS_PH; k++) s += m_hist[k] * m_coef[k*OS + p];
        r = (SHIFT > 0) ? ((s + (1 << (SHIFT - 1))) >>> SHIFT) : s;
        if (r > OUT_MAX) r = OUT_MAX;
        if (r < OUT_MIN) r = OUT_MIN;
        return r;
    endfunction

    initial begin
        for (int k = 0; k < N_TAPS_PH; k++) m_hist[k] = 0;
        for (int a = 0; a < NC; a++) m_coef[a] = 0;
        forever begin
            @(posedge clock);
            if (i_reset) begin
                for (int k = 0; k < N_TAPS_PH; k++) m_hist[k] = 0;
                for (int a = 0; a < NC; a++) m_coef[a] = 0;
                m_phase = 0;
                pend_valid = 1'b0;
                exp_valid = 1'b0;
                exp_data = 0;
                exp_phase = 0;
            end else begin
                exp_valid = pend_valid;
                if (pend_valid) begin
                    exp_data = shape(pend_phase);
                    exp_phase = pend_phase;
                end
                pend_valid = 1'b0;
                if (i_enable) begin
                    if (m_phase == 0) begin
                        for (int k = N_TAPS_PH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
                        m_hist[0] = i_valid ? map_ref(i_data, i_mode) : 0;
                    end
                    pend_valid = 1'b1;
                    pend_phase = m_phase;
                    m_phase = (m_phase + 1) % OS;
                end
                if (i_coef_we && (int'(i_coef_addr) < NC)) begin
                    m_coef[int'(i_coef_addr)] = int'($signed(i_coef_data));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            checkOutput("o_valid", int'(o_valid), int'(exp_valid));
            checkOutput("o_data", int'($signed(o_data)), exp_data);
            checkOutput("o_phase", int'(o_phase), exp_phase);
            checkOutput("o_ready", int'(o_ready), (i_enable && (m_phase == 0)) ? 1 : 0);
            if (exp_valid) exp_log.push_back(exp_data);
            if (o_valid) dut_log.push_back(int'($signed(o_data)));
        end
    end

    task automatic checkLit(input string name, input int idx, input int lit);
        if (idx < exp_log.size()) checkOutput({name, "_model"}, exp_log[idx], lit);
        else checkOutput({name, "_model_len"}, exp_log.size(), idx + 1);
        if (idx < dut_log.size()) checkOutput({name, "_dut"}, dut_log[idx], lit);
        else checkOutput({name, "_dut_len"}, dut_log.size(), idx + 1);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        i_enable = 1'b0;
        i_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic clearLogs();
        dut_log.delete();
        exp_log.delete();
    endtask

    task automatic resetDut();
        i_enable = 1'b0;
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
    endtask

    task automatic writeCoef(input int addr, input int value);
        i_coef_we = 1'b1;
        i_coef_addr = AW'(addr);
        i_coef_data = NB_COEF'(value);
        step();
        i_coef_we = 1'b0;
    endtask

    // One symbol period; the off-phase cycles carry junk that must be ignored.
    task automatic applyStimulus(input logic valid, input logic [1:0] data, input logic mode);
        i_enable = 1'b1;
        i_valid = valid;
        i_data = data;
        i_mode = mode;
        step();
        i_valid = 1'b1;
        i_data = ~data;
        i_mode = ~mode;
        repeat (OS - 1) step();
        i_valid = 1'b0;
        i_mode = mode;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (2) step();
        i_reset = 1'b0;
        checkOutput("reset_o_valid", int'(o_valid), 0);
        checkOutput("reset_o_data", int'($signed(o_data)), 0);
        checkOutput("reset_o_phase", int'(o_phase), 0);

        // Impulse response, -1 history and underrun slot
        for (int a = 0; a < NC; a++) writeCoef(a, 8 * (a / OS) + (a % OS) + 1);
        idle(3);
        clearLogs();
        applyStimulus(1'b1, 2'b01, 1'b0);
        for (int j = 0; j < 5; j++) applyStimulus(1'b1, 2'b00, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b0);
        idle(3);
        checkLit("impulse_p0", 0, 1);
        checkLit("impulse_p3", 3, 2);
        checkLit("second_sym_p0", 4, 4);
        checkLit("neg_history_p0", 24, -62);
        checkLit("underrun_p0", 28, -53);

        // Saturation both ways
        resetDut();
        for (int a = 0; a < NC; a++) writeCoef(a, 127);
        idle(2);
        clearLogs();
        for (int j = 0; j < 8; j++) applyStimulus(1'b1, 2'b01, 1'b0);
        idle(3);
        checkLit("sat_hi_p0", 28, 127);
        checkLit("sat_hi_p3", 31, 127);
        clearLogs();
        for (int j = 0; j < 8; j++) applyStimulus(1'b1, 2'b00, 1'b0);
        idle(3);
        checkLit("sat_lo_p0", 28, -128);
        checkLit("sat_lo_p3", 31, -128);

        // PAM4 levels through a single tap
        resetDut();
        writeCoef(0, 64);
        idle(2);
        clearLogs();
        applyStimulus(1'b1, 2'b10, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b1);
        idle(3);
        checkLit("pam4_10", 0, 96);
        checkLit("pam4_00", 4, -96);
        checkLit("pam4_01", 8, -32);
        checkLit("pam4_11", 12, 32);
        checkLit("pam4_p1_zero", 1, 0);
        checkLit("pam4_p3_zero", 7, 0);

        // Enable hold mid-symbol
        writeCoef(2, 40);
        idle(2);
        i_enable = 1'b1;
        i_valid = 1'b1;
        i_data = 2'b01;
        i_mode = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        step();
        i_enable = 1'b0;
        step();
        checkOutput("hold_last_valid", int'(o_valid), 1);
        checkOutput("hold_last_phase", int'(o_phase), 2);
        checkOutput("hold_last_data", int'($signed(o_data)), 20);
        step();
        repeat (3) step();
        checkOutput("hold_valid", int'(o_valid), 0);
        checkOutput("hold_phase", int'(o_phase), 2);
        checkOutput("hold_data", int'($signed(o_data)), 20);
        checkOutput("hold_ready", int'(o_ready), 0);
        i_enable = 1'b1;
        #1;
        checkOutput("resume_ready_phase3", int'(o_ready), 0);
        step();
        checkOutput("resume_ready_phase0", int'(o_ready), 1);
        applyStimulus(1'b1, 2'b00, 1'b1);
        idle(3);

        // Mid-stream reset clears history and coefficients, overriding a write
        i_enable = 1'b1;
        i_valid = 1'b1;
        i_data = 2'b01;
        i_mode = 1'b0;
        step();
        i_valid = 1'b0;
        step();
        i_reset = 1'b1;
        i_coef_we = 1'b1;
        i_coef_addr = '0;
        i_coef_data = 8'd100;
        step();
        i_reset = 1'b0;
        i_coef_we = 1'b0;
        #1;
        checkOutput("midreset_valid", int'(o_valid), 0);
        checkOutput("midreset_data", int'($signed(o_data)), 0);
        checkOutput("midreset_ready", int'(o_ready), 1);
        idle(2);
        writeCoef(20, 64);
        idle(2);
        clearLogs();
        for (int j = 0; j < 6; j++) applyStimulus(1'b1, 2'b01, 1'b0);
        idle(3);
        checkLit("cleared_hist_p0", 0, 0);
        checkLit("cleared_hist_p1", 1, 0);
        checkLit("tap5_pre", 16, 0);
        checkLit("tap5_hit", 20, 32);

        // Out-of-range write and write colliding with a compute
        resetDut();
        writeCoef(0, 64);
        writeCoef(NC, 127);
        writeCoef(31, 100);
        idle(2);
        clearLogs();
        applyStimulus(1'b1, 2'b01, 1'b0);
        i_enable = 1'b1;
        i_valid = 1'b1;
        i_data = 2'b01;
        i_mode = 1'b0;
        step();
        i_valid = 1'b0;
        i_coef_we = 1'b1;
        i_coef_addr = '0;
        i_coef_data = 8'd32;
        step();
        i_coef_we = 1'b0;
        step();
        step();
        applyStimulus(1'b1, 2'b00, 1'b0);
        idle(3);
        checkLit("oor_p0", 0, 32);
        checkLit("oor_p2", 2, 0);
        checkLit("collide_old", 4, 32);
        checkLit("collide_new", 8, -16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
